// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: walks an external 1-bit full adder across two
// WIDTH-bit operands LSB first and returns {cout, sum} with a done pulse.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_aSh;
    logic [WIDTH-1:0] r_bSh;
    logic [WIDTH-1:0] r_sumSh;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_count;
    logic             r_faA;
    logic             r_faB;
    logic             r_faCin;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;

    logic [WIDTH-1:0] w_aNext;
    logic [WIDTH-1:0] w_bNext;
    logic [WIDTH-1:0] w_sumNext;

    // The new sum bit enters at the MSB so the LSB-first stream ends up in place.
    assign w_aNext   = r_aSh >> 1;
    assign w_bNext   = r_bSh >> 1;
    assign w_sumNext = WIDTH'({fa_sum, r_sumSh} >> 1);

    // r_faCin doubles as the running carry; the adder pins are loaded one
    // edge ahead so they come straight from flops and read 0 outside RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_aSh   <= '0;
            r_bSh   <= '0;
            r_sumSh <= '0;
            r_sum   <= '0;
            r_count <= '0;
            r_faA   <= 1'b0;
            r_faB   <= 1'b0;
            r_faCin <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_aSh   <= a;
                        r_bSh   <= b;
                        r_sumSh <= '0;
                        r_count <= '0;
                        r_faA   <= a[0];
                        r_faB   <= b[0];
                        r_faCin <= cin;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sumSh <= w_sumNext;
                    r_aSh   <= w_aNext;
                    r_bSh   <= w_bNext;
                    r_count <= r_count + CW'(1);
                    if (r_count == LAST) begin
                        r_sum   <= w_sumNext;
                        r_cout  <= fa_cout;
                        r_faA   <= 1'b0;
                        r_faB   <= 1'b0;
                        r_faCin <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_faA   <= w_aNext[0];
                        r_faB   <= w_bNext[0];
                        r_faCin <= fa_cout;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign fa_a   = r_faA;
    assign fa_b   = r_faB;
    assign fa_cin = r_faCin;
    assign busy   = r_busy;
    assign done   = r_done;
    assign sum    = r_sum;
    assign cout   = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: a behavioural full adder closes the
// loop and results are compared against plain integer addition.
module tb_serial_add_ctrl;

    localparam int W   = 8;
    localparam int WIN = W + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         faA, faB, faCin, faSum, faCout;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    logic         start1 = 1'b0;
    logic         cin1   = 1'b0;
    logic [0:0]   a1     = '0;
    logic [0:0]   b1     = '0;
    logic         faA1, faB1, faCin1, faSum1, faCout1;
    logic         busy1, done1, cout1;
    logic [0:0]   sum1;

    // Behavioural full adders standing in for the shared adder cell.
    assign faSum   = faA ^ faB ^ faCin;
    assign faCout  = (faA & faB) | (faA & faCin) | (faB & faCin);
    assign faSum1  = faA1 ^ faB1 ^ faCin1;
    assign faCout1 = (faA1 & faB1) | (faA1 & faCin1) | (faB1 & faCin1);

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .fa_a(faA), .fa_b(faB), .fa_cin(faCin), .fa_sum(faSum), .fa_cout(faCout),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .fa_a(faA1), .fa_b(faB1), .fa_cin(faCin1), .fa_sum(faSum1), .fa_cout(faCout1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    int checks = 0;
    int errors = 0;

    logic [WIN-1:0] obsBusy, obsDone, obsFaA, obsFaB, obsFaCin;
    logic [W-1:0]   obsSum [1:WIN];
    logic           obsCout[1:WIN];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] refAdd(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + (W+1)'(c);
    endfunction

    // Carry into bit k is the carry out of adding the low k bits.
    function automatic logic [WIN-1:0] refCarryTrace(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [WIN-1:0] r;
        longint mask, tmp;
        r = '0;
        for (int k = 0; k < W; k++) begin
            mask = (64'd1 << k) - 1;
            tmp  = (longint'(x) & mask) + (longint'(y) & mask) + longint'(c);
            r[k] = tmp[k];
        end
        return r;
    endfunction

    // Start one operation (edge 0) and record cycles 1..WIN; inputs are
    // scrambled after acceptance and an optional extra start is pulsed.
    task automatic runOp(input logic [W-1:0] opA, input logic [W-1:0] opB, input logic opCin,
                         input int intrCycle, input logic [W-1:0] intrA, input logic [W-1:0] intrB);
        a = opA; b = opB; cin = opCin; start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        for (int c = 1; c <= WIN; c++) begin
            obsBusy[c-1]  = busy;
            obsDone[c-1]  = done;
            obsFaA[c-1]   = faA;
            obsFaB[c-1]   = faB;
            obsFaCin[c-1] = faCin;
            obsSum[c]     = sum;
            obsCout[c]    = cout;
            if (c == intrCycle) begin
                start = 1'b1; a = intrA; b = intrB; cin = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, cout, faA, faB, faCin, sum} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %b expected all zero", {busy, done, cout, faA, faB, faCin, sum});
        end
        checks++;
        if ({busy1, done1, cout1, faA1, faB1, faCin1, sum1} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state_w1: got %b expected all zero", {busy1, done1, cout1, faA1, faB1, faCin1, sum1});
        end
    endtask

    task automatic test_zero();
        runOp(8'h00, 8'h00, 1'b0, 0, 8'h00, 8'h00);
        checks++;
        if (obsBusy !== 10'h0FF) begin
            errors++; $display("[TB] FAIL zero_busy: got %b expected %b", obsBusy, 10'h0FF);
        end
        checks++;
        if (obsDone !== 10'h100) begin
            errors++; $display("[TB] FAIL zero_done: got %b expected %b", obsDone, 10'h100);
        end
        checks++;
        if ({obsCout[W+1], obsSum[W+1]} !== 9'h000) begin
            errors++; $display("[TB] FAIL zero_result: got %h expected 000", {obsCout[W+1], obsSum[W+1]});
        end
    endtask

    task automatic test_carry_chain();
        runOp(8'hFF, 8'h01, 1'b0, 0, 8'h00, 8'h00);
        checks++;
        if ({obsCout[W+1], obsSum[W+1]} !== 9'h100) begin
            errors++; $display("[TB] FAIL chain_result: got %h expected 100", {obsCout[W+1], obsSum[W+1]});
        end
        checks++;
        if (obsFaCin !== 10'h0FE) begin
            errors++; $display("[TB] FAIL chain_fa_cin: got %b expected %b", obsFaCin, 10'h0FE);
        end
    endtask

    task automatic test_hold();
        runOp(8'hA5, 8'h5A, 1'b1, 0, 8'h00, 8'h00);
        checks++;
        if ({obsCout[W+1], obsSum[W+1]} !== 9'h100) begin
            errors++; $display("[TB] FAIL hold_first: got %h expected 100", {obsCout[W+1], obsSum[W+1]});
        end
        runOp(8'h3C, 8'h0F, 1'b0, 0, 8'h00, 8'h00);
        for (int c = 1; c <= W; c++) begin
            checks++;
            if ({obsCout[c], obsSum[c]} !== 9'h100) begin
                errors++; $display("[TB] FAIL hold_prev_c%0d: got %h expected 100", c, {obsCout[c], obsSum[c]});
            end
        end
        checks++;
        if ({obsCout[W+1], obsSum[W+1]} !== 9'h04B) begin
            errors++; $display("[TB] FAIL hold_second: got %h expected 04b", {obsCout[W+1], obsSum[W+1]});
        end
    endtask

    task automatic test_ignore_start();
        runOp(8'h12, 8'h34, 1'b0, 3, 8'hFF, 8'hFF);
        for (int c = 1; c <= W; c++) begin
            checks++;
            if (obsSum[c] !== 8'h4B) begin
                errors++; $display("[TB] FAIL ignore_hold_c%0d: got %h expected 4b", c, obsSum[c]);
            end
        end
        checks++;
        if (obsDone !== 10'h100) begin
            errors++; $display("[TB] FAIL ignore_done: got %b expected %b", obsDone, 10'h100);
        end
        checks++;
        if ({obsCout[W+1], obsSum[W+1]} !== 9'h046) begin
            errors++; $display("[TB] FAIL ignore_result: got %h expected 046", {obsCout[W+1], obsSum[W+1]});
        end
        checks++;
        if (obsBusy[WIN-1] !== 1'b0) begin
            errors++; $display("[TB] FAIL ignore_no_queue: got busy %b expected 0", obsBusy[WIN-1]);
        end
    endtask

    task automatic test_reset_midrun();
        a = 8'h77; b = 8'h66; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, cout, faA, faB, faCin, sum} !== '0) begin
            errors++; $display("[TB] FAIL midrun_reset: got %b expected all zero", {busy, done, cout, faA, faB, faCin, sum});
        end
        for (int c = 0; c < W + 2; c++) begin
            tick();
            checks++;
            if ({busy, done} !== 2'b00) begin
                errors++; $display("[TB] FAIL midrun_no_resume_c%0d: got %b expected 00", c, {busy, done});
            end
        end
        runOp(8'h01, 8'h01, 1'b0, 0, 8'h00, 8'h00);
        checks++;
        if ({obsCout[W+1], obsSum[W+1]} !== 9'h002) begin
            errors++; $display("[TB] FAIL midrun_after: got %h expected 002", {obsCout[W+1], obsSum[W+1]});
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x, y;
        logic         c0;
        logic [W:0]   exp;
        bit           seen;
        x = W'($urandom); y = W'($urandom); c0 = 1'($urandom);
        exp = refAdd(x, y, c0);
        a = x; b = y; cin = c0; start = 1'b1;
        tick();
        for (int c = 1; c <= W; c++) tick();
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_done_first: got %b expected 1", done);
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("[TB] FAIL b2b_idle_gap: got %b expected 00", {busy, done});
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_accept: got %b expected 1", busy);
        end
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4 * W && !seen; c++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("[TB] FAIL b2b_timeout: got no done expected done");
        end else if ({cout, sum} !== exp) begin
            errors++; $display("[TB] FAIL b2b_result: got %h expected %h", {cout, sum}, exp);
        end
        tick(); tick();
    endtask

    task automatic test_random();
        logic [W-1:0]   x, y;
        logic           c0;
        logic [W:0]     exp;
        logic [WIN-1:0] expCarry;
        int             intr;
        for (int n = 0; n < 20; n++) begin
            x = W'($urandom); y = W'($urandom); c0 = 1'($urandom);
            intr = $urandom_range(0, W + 1);
            exp = refAdd(x, y, c0);
            expCarry = refCarryTrace(x, y, c0);
            runOp(x, y, c0, intr, W'($urandom), W'($urandom));
            checks++;
            if ({obsBusy, obsDone} !== {WIN'({W{1'b1}}), WIN'(1) << W}) begin
                errors++; $display("[TB] FAIL rand%0d_timing: got %b/%b", n, obsBusy, obsDone);
            end
            checks++;
            if ({obsFaA, obsFaB} !== {WIN'(x), WIN'(y)}) begin
                errors++; $display("[TB] FAIL rand%0d_fa_ab: got %b/%b expected %b/%b", n, obsFaA, obsFaB, WIN'(x), WIN'(y));
            end
            checks++;
            if (obsFaCin !== expCarry) begin
                errors++; $display("[TB] FAIL rand%0d_fa_cin: got %b expected %b", n, obsFaCin, expCarry);
            end
            checks++;
            if ({obsCout[W+1], obsSum[W+1]} !== exp) begin
                errors++; $display("[TB] FAIL rand%0d_result: got %h expected %h", n, {obsCout[W+1], obsSum[W+1]}, exp);
            end
        end
    endtask

    task automatic test_width1();
        logic [1:0] exp;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++;
        if ({busy1, faA1, faB1, faCin1} !== 4'b1111) begin
            errors++; $display("[TB] FAIL w1_run: got %b expected 1111", {busy1, faA1, faB1, faCin1});
        end
        tick();
        checks++;
        if ({busy1, done1, cout1, sum1} !== 4'b0111) begin
            errors++; $display("[TB] FAIL w1_done: got %b expected 0111", {busy1, done1, cout1, sum1});
        end
        tick();
        for (int k = 0; k < 8; k++) begin
            a1 = k[0]; b1 = k[1]; cin1 = k[2];
            exp = 2'(k[0]) + 2'(k[1]) + 2'(k[2]);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            a1 = ~a1; b1 = ~b1;
            tick();
            checks++;
            if ({done1, cout1, sum1} !== {1'b1, exp}) begin
                errors++; $display("[TB] FAIL w1_combo%0d: got %b expected %b", k, {done1, cout1, sum1}, {1'b1, exp});
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_carry_chain();
        test_hold();
        test_ignore_start();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        test_width1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
